// File: rtl/muller_c_pkg.sv
// Shared definitions for the muller_c_array C-element array.
// Holds the default parameter values, the per-channel state record and a
// saturating increment helper.
package muller_c_pkg;

   localparam int unsigned CHANNELS_DEF   = 2;
   localparam int unsigned INPUTS_DEF     = 3;
   localparam int unsigned STABLE_CYC_DEF = 1;
   localparam int unsigned CNT_W_DEF      = 8;

   // Filter count field width; supports STABLE_CYC up to 65535.
   localparam int unsigned FCNT_W = 16;

   typedef struct packed {
      logic              c;
      logic [FCNT_W-1:0] f_cnt;
   } c_state_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                           input logic [31:0] max);
      return (cnt >= max) ? max : cnt + 32'd1;
   endfunction

endpackage

// File: rtl/muller_c_cell.sv
// One channel of the C-element array: target detection, stability filter,
// registered C output and saturating flip counter.
// Inputs whose mask bit is set take part only in the rise condition.
module muller_c_cell
   import muller_c_pkg::*;
#(
   parameter int unsigned INPUTS     = INPUTS_DEF,
   parameter int unsigned STABLE_CYC = STABLE_CYC_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF,
   parameter logic        RESET_VAL  = 1'b0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [INPUTS-1:0] c_in_i,
   input  logic [INPUTS-1:0] mask_i,
   input  logic              en_i,
   input  logic              clr_i,
   output logic              c_o,
   output logic [CNT_W-1:0]  cnt_o,
   output logic              c_nxt_o,
   output logic              fzero_nxt_o
);

   localparam logic [31:0] CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);
   localparam logic [FCNT_W-1:0] F_LAST = FCNT_W'(STABLE_CYC - 1);

   c_state_t         st_q, st_d;
   logic [CNT_W-1:0] tog_q, tog_d;
   logic             rise, fall, target, flip;

   // Target value, filter progression and flip-counter update.
   always_comb begin
      st_d  = st_q;
      tog_d = tog_q;
      flip  = 1'b0;
      rise  = &c_in_i;
      fall  = ~|(c_in_i & ~mask_i);
      if (rise)      target = 1'b1;
      else if (fall) target = 1'b0;
      else           target = st_q.c;

      if (!en_i) begin
         st_d.f_cnt = '0;
      end else if (target == st_q.c) begin
         st_d.f_cnt = '0;
      end else if (st_q.f_cnt == F_LAST) begin
         st_d.c     = target;
         st_d.f_cnt = '0;
         flip       = 1'b1;
      end else begin
         st_d.f_cnt = st_q.f_cnt + FCNT_W'(1);
      end

      if (clr_i)     tog_d = '0;
      else if (flip) tog_d = CNT_W'(sat_inc(32'(tog_q), CNT_MAX));
   end

   // Channel state register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         st_q.c     <= RESET_VAL;
         st_q.f_cnt <= '0;
         tog_q      <= '0;
      end else begin
         st_q  <= st_d;
         tog_q <= tog_d;
      end
   end

   assign c_o         = st_q.c;
   assign cnt_o       = tog_q;
   assign c_nxt_o     = st_d.c;
   assign fzero_nxt_o = (st_d.f_cnt == '0);

endmodule

// File: rtl/muller_c_array.sv
// Clocked array of CHANNELS Muller C-elements with stability filter,
// per-channel enable, saturating flip counters and a completion flag.
// Optional feature macro: MULLER_C_ASYM_EN adds the asym_mask port
// ("plus" inputs that only participate in the rise condition).
module muller_c_array
   import muller_c_pkg::*;
#(
   parameter int unsigned CHANNELS   = CHANNELS_DEF,
   parameter int unsigned INPUTS     = INPUTS_DEF,
   parameter int unsigned STABLE_CYC = STABLE_CYC_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF,
   parameter logic        RESET_VAL  = 1'b0
) (
   input  logic                         wb_clk_i,
   input  logic                         wb_rst_n,
   input  logic [CHANNELS*INPUTS-1:0]   c_in,
   input  logic [CHANNELS-1:0]          ch_en,
   input  logic                         clr_cnt,
`ifdef MULLER_C_ASYM_EN
   input  logic [CHANNELS*INPUTS-1:0]   asym_mask,
`endif
   output logic [CHANNELS-1:0]          c_out,
   output logic [CHANNELS*CNT_W-1:0]    tog_cnt,
   output logic                         all_done
);

   logic [CHANNELS*INPUTS-1:0] mask_w;
   logic [CHANNELS-1:0]        c_nxt, fz_nxt;
   logic                       all_done_q, all_done_d;

`ifdef MULLER_C_ASYM_EN
   assign mask_w = asym_mask;
`else
   assign mask_w = '0;
`endif

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      muller_c_cell #(
         .INPUTS     (INPUTS),
         .STABLE_CYC (STABLE_CYC),
         .CNT_W      (CNT_W),
         .RESET_VAL  (RESET_VAL)
      ) u_cell (
         .clk_i       (wb_clk_i),
         .rst_ni      (wb_rst_n),
         .c_in_i      (c_in[k*INPUTS +: INPUTS]),
         .mask_i      (mask_w[k*INPUTS +: INPUTS]),
         .en_i        (ch_en[k]),
         .clr_i       (clr_cnt),
         .c_o         (c_out[k]),
         .cnt_o       (tog_cnt[k*CNT_W +: CNT_W]),
         .c_nxt_o     (c_nxt[k]),
         .fzero_nxt_o (fz_nxt[k])
      );
   end

   // Completion: next outputs all equal and no channel mid-filter.
   always_comb begin
      all_done_d = ((&c_nxt) | ~(|c_nxt)) & (&fz_nxt);
   end

   // Completion flag register; reset reports done.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n) all_done_q <= 1'b1;
      else           all_done_q <= all_done_d;
   end

   assign all_done = all_done_q;

endmodule
